// File: rtl/rr_arb4_ctrl_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter (package rr_arb_pkg).
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arb4_ctrl_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arb4_ctrl_if;
    import rr_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               busy;

    modport master (output req, input gnt, input gnt_id, input busy);
    modport slave  (input req, output gnt, output gnt_id, output busy);

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set, non-excluded req scanning from ptr+1 with wrap.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic [NUM_REQ-1:0] excl,
    output logic               vld,
    output logic [ID_W-1:0]    id
);

    logic [ID_W-1:0] idx;

    always_comb begin
        vld = 1'b0;
        id  = '0;
        idx = '0;
        // k runs 1..4 so the last position examined is ptr itself
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!vld && req[idx] && !excl[idx]) begin
                vld = 1'b1;
                id  = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// Four-requester round-robin arbiter with registered one-hot grant and owner index.
// Define HOLD_TIMEOUT_EN to force rotation after HOLD_MAX consecutive granted cycles.
module rr_arb4_ctrl
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    rr_arb4_ctrl_if.slave bus
);

`ifdef HOLD_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(HOLD_MAX - 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;

    logic [ID_W-1:0]    pick_ptr;
    logic [NUM_REQ-1:0] pick_excl;
    logic               pick_vld;
    logic [ID_W-1:0]    pick_id;
    logic               owner_req;
    logic               cnt_at_sat;

    // While owned the scan starts after the owner and skips it; on a release
    // req[owner] is already low, so the exclusion only matters for timeouts.
    assign pick_ptr   = (state_q == ST_OWNED) ? id_q : ptr_q;
    assign pick_excl  = (state_q == ST_OWNED) ? onehot4(id_q) : '0;
    assign owner_req  = bus.req[id_q];
    assign cnt_at_sat = (cnt_q == CNT_SAT);

    rr_pick4 u_pick (
        .req  (bus.req),
        .ptr  (pick_ptr),
        .excl (pick_excl),
        .vld  (pick_vld),
        .id   (pick_id)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_OWNED;
                    id_d    = pick_id;
                    cnt_d   = '0;
                end
            end
            ST_OWNED: begin
                if (!owner_req) begin
                    ptr_d = id_q;
                    cnt_d = '0;
                    if (pick_vld) begin
                        id_d = pick_id;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (TIMEOUT_EN && cnt_at_sat && pick_vld) begin
                    ptr_d = id_q;
                    id_d  = pick_id;
                    cnt_d = '0;
                end else if (!cnt_at_sat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        gnt_d = (state_d == ST_OWNED) ? onehot4(id_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = id_q;
    assign bus.busy   = (state_q == ST_OWNED);

endmodule

// File: doc/rr_arb4_ctrl.md
Name: rr_arb4_ctrl

Overview:
- Four-requester round-robin arbiter that shares one resource.
- Issues a registered one-hot grant (gnt[3:0]) plus a binary owner index (gnt_id[1:0]). This is the same 2-bit-to-one-hot mapping the team's registered 2-to-4 decode stage uses.
- Sits in front of the shared decode/output stage and decides which requester drives it on each cycle.
- Grant is held while the owner keeps its request high. Rotation is fair, with an optional hold timeout.

Parameters:
- HOLD_MAX, 8: maximum consecutive granted cycles per owner before forced rotation. Active only with HOLD_TIMEOUT_EN. Legal range 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  in  1  system clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset, sampled on posedge clk.
- req  in  4  request vector; req[i] high means requester i wants the resource.
- gnt  out  4  registered one-hot grant; all-zero when idle.
- gnt_id  out  2  registered index of the current owner; meaningful only while busy=1.
- busy  out  1  registered; high when any grant is active (equals OR of gnt).

Behaviour:
- Reset (rst=1 at a posedge): gnt=4'b0000, gnt_id=2'd0, busy=0, hold_cnt=0, last-owner pointer ptr=2'd3, so requester 0 has top priority first. Reset wins over every other event, including mid-grant: gnt clears at that edge.
- States are IDLE (busy=0) and OWNED (busy=1).
- Pick function: scan from ptr+1 upward, wrapping 3 to 0, and select the first i with req[i]=1.
- IDLE:
  - If req!=0 at an edge, go to OWNED at that edge with gnt_id=pick and gnt=one-hot(pick).
  - Latency: one edge from req sampled high to gnt visible.
  - If req==0, stay in IDLE.
- OWNED, owner o:
  - req[o]=1 and no timeout: hold. gnt unchanged; hold_cnt increments and saturates at HOLD_MAX-1.
  - req[o]=0 at an edge: release. Set ptr=o. If any other req is high, grant the next pick at the same edge, with no dead cycle. Otherwise go to IDLE with gnt=0.
  - Non-owner requests are ignored while held; they never preempt the owner.
- Timeout (HOLD_TIMEOUT_EN only): at an edge where hold_cnt==HOLD_MAX-1, req[o]=1, and some other req[j]=1:
  - Set ptr=o and grant pick(excluding o) at that edge.
  - The old owner loses its grant even though its request is still high.
  - If no other request is pending, the owner keeps the grant and hold_cnt stays saturated.
- hold_cnt resets to 0 on every new grant, including a regrant to a different owner on the release edge.
- Invariants: gnt is always one-hot or zero; gnt==one-hot(gnt_id) whenever busy=1; at most one ownership change per edge.
- When the owner drops its request at the same edge as a new request arrives, the pick uses the updated ptr=o.

Optional Feature:
- Macro HOLD_TIMEOUT_EN.
- Defined: the hold-limit rotation described above is enforced, and HOLD_MAX is honoured.
- Undefined: no timeout. The owner holds the grant indefinitely while req[o]=1; hold_cnt logic and HOLD_MAX are unused and may be optimised away. All other behaviour is identical.

Decomposition:
- Shared package rr_arb_pkg holds:
  - NUM_REQ=4
  - ID_W=2
  - state enum {ST_IDLE, ST_OWNED}
  - function onehot4(id) returning 4-bit one-hot
- One natural sub-module, rr_pick4: purely combinational. Takes req[3:0], ptr[1:0] and an exclude mask; returns valid and id[1:0]. Instantiated once by rr_arb4_ctrl.

Test Plan:
- Reset then idle: rst=1 for 2 edges, req=0 → gnt=0000, busy=0, gnt_id=0; stays so for 5 edges with req=0.
- First grant and priority: after reset, req=1010 → next edge gnt=0010, gnt_id=1. Hold req=1010 for 3 edges → gnt unchanged.
- Round-robin release: owner 1, then req changes to 1000 → same edge gnt=1000, gnt_id=3, no zero cycle. Then req=0000 → gnt=0000, busy=0.
- Fair wrap: ptr=3, req=1111 with each owner dropping its request for one cycle after its grant → grant order 0,1,2,3,0.
- Timeout (HOLD_TIMEOUT_EN, HOLD_MAX=4): req=0011 held continuously → gnt=0001 for 4 cycles, then 0010 for 4 cycles, alternating. With macro undefined → gnt=0001 forever.
- Reset mid-grant: owner 2 active with req=0100, assert rst for one edge → gnt=0000 at that edge. After release, req=0100 → gnt=0100 one edge later.
